qdriip_ui_mem_model: RTL and testbench
======================================

// Module: qdriip_ui_mem_model
// PURPOSE
// Synthesizable responder for the QDRII+ MC user interface: emulates the memory-controller side of
// app_wr/app_rd so the AXI-QDRII+ bridge and AXI master can run without the MIG core or SRAM.
// Backed by an internal RAM with byte-lane writes, a fixed read latency and an emulated calibration.
// Drops in where the MC UI ports sit; used for board bring-up loopback and fast simulation.
// PARAMETERS
// ADDR_WIDTH      22  UI address width (app_wr_addr/app_rd_addr)
// DATA_WIDTH      72  UI data width; must equal BW_WIDTH*LANE_W
// BW_WIDTH        8   byte-write-enable lanes; LANE_W = DATA_WIDTH/BW_WIDTH (9)
// MEM_AW          10  RAM address bits; depth = 2**MEM_AW words
// RD_LATENCY      4   cycles from app_rd_cmd to app_rd_valid; legal range 2..16
// CALIB_CYCLES    64  cycles after reset before init_calib_complete rises; >=1
// PORTS
// clk                  in   1           UI clock; all logic on rising edge
// rst_n                in   1           synchronous active-low reset
// app_wr_cmd           in   1           write strobe, one word per asserted cycle
// app_wr_addr          in   ADDR_WIDTH  write word address
// app_wr_data          in   DATA_WIDTH  write data
// app_wr_bw_n          in   BW_WIDTH    active-low lane enables; bit i covers data[i*LANE_W +: LANE_W]
// app_rd_cmd           in   1           read strobe, one word per asserted cycle
// app_rd_addr          in   ADDR_WIDTH  read word address
// app_rd_data          out  DATA_WIDTH  read data, qualified by app_rd_valid
// app_rd_valid         out  1           one-cycle pulse per accepted read, in command order
// init_calib_complete  out  1           high once emulated calibration done; stays high until reset
// oor_cnt              out  16          saturating count of accepted cmds with addr[ADDR_WIDTH-1:MEM_AW]!=0
// drop_cnt             out  16          saturating count of cmds (wr and rd each) seen while not calibrated
// BEHAVIOUR
// - Reset (rst_n=0 at edge): app_rd_valid=0, app_rd_data=0, init_calib_complete=0, oor_cnt=0,
//   drop_cnt=0, read pipeline valids cleared, FSM->CALIB, calib counter=0. RAM contents NOT cleared.
// - FSM: CALIB: counter increments each cycle; at counter==CALIB_CYCLES-1 -> READY next cycle.
//   READY: init_calib_complete=1 (registered, first high cycle = CALIB_CYCLES after reset release).
//   READY is terminal; only rst_n returns to CALIB.
// - In CALIB, wr/rd cmds have no effect on RAM or read pipe; each asserted cmd adds 1 to drop_cnt
//   (wr and rd same cycle adds 2, saturating at 16'hFFFF).
// - Write (READY, app_wr_cmd=1): for each lane i with bw_n[i]==0, RAM[addr[MEM_AW-1:0]] lane i <=
//   data lane; lanes with bw_n[i]==1 unchanged. bw_n all ones = no-op write (still counted if oor).
// - Read (READY, app_rd_cmd=1 at cycle T): RAM[addr[MEM_AW-1:0]] sampled at T; app_rd_valid=1 and
//   app_rd_data=word at T+RD_LATENCY. Full throughput: one read per cycle, no backpressure, no gaps
//   inserted. app_rd_data holds last value when valid=0.
// - Same-cycle wr and rd to same RAM address: read returns OLD data (read-before-write).
//   Read issued at T+1 after a write at T returns new data.
// - Address aliasing: upper bits ignored for storage (wrap modulo depth); oor_cnt +1 per accepted
//   command with nonzero upper bits (wr and rd same cycle both oor -> +2), saturating.
// - Reset mid-operation: in-flight reads discarded (no valid emitted after reset); writes in the
//   reset cycle are not performed.
// - Pipeline: RD_LATENCY-deep shift of {valid, data}; RAM read stage counts as stage 1 (BRAM-inferable).
// TESTING
// 1 Reset release, no cmds -> init_calib_complete rises exactly 64 cycles later; rd_valid stays 0.
// 2 wr addr 0x5 data 72'h12_3456_789A_BCDE_F012 bw_n 8'h00 at READY, rd 0x5 at T -> valid at T+4, data match.
// 3 Write all-ones to 0x7, then wr 0x7 data 0 bw_n 8'hFE, rd 0x7 -> only bits [8:0] zero, rest ones.
// 4 Back-to-back reads addr 0..9 every cycle -> 10 consecutive valid pulses, data in order, no gaps.
// 5 wr/rd to 0x400 and 0x3_FC00 (MEM_AW=10) -> alias word 0; oor_cnt=4; drop_cnt unchanged.
// 6 Cmds during CALIB (3 wr, 2 rd) -> drop_cnt=5, RAM unchanged; rst_n pulse with 3 reads in flight -> no valids.

Source files
------------

// File: rtl/qdriip_ui_mem_model.sv
// QDRII+ MC user-interface responder: byte-lane RAM, fixed read latency,
// emulated calibration and drop/out-of-range command counters.
module qdriip_ui_mem_model #(
    parameter int ADDR_WIDTH   = 22,
    parameter int DATA_WIDTH   = 72,
    parameter int BW_WIDTH     = 8,
    parameter int MEM_AW       = 10,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  app_wr_cmd,
    input  logic [ADDR_WIDTH-1:0] app_wr_addr,
    input  logic [DATA_WIDTH-1:0] app_wr_data,
    input  logic [BW_WIDTH-1:0]   app_wr_bw_n,
    input  logic                  app_rd_cmd,
    input  logic [ADDR_WIDTH-1:0] app_rd_addr,
    output logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  app_rd_valid,
    output logic                  init_calib_complete,
    output logic [15:0]           oor_cnt,
    output logic [15:0]           drop_cnt
);

    localparam int LANE_W = DATA_WIDTH / BW_WIDTH;
    localparam int DEPTH  = 1 << MEM_AW;
    localparam int CW     = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam int PD     = RD_LATENCY - 1;

    typedef enum logic {
        CALIB,
        READY
    } state_e;

    state_e                state_q;
    logic [CW-1:0]         calib_cnt_q;
    logic                  calib_done_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PD-1:0]         pipe_v_q;
    logic [DATA_WIDTH-1:0] pipe_d_q [PD];
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [15:0]           oor_cnt_q;
    logic [15:0]           oor_cnt_d;
    logic [15:0]           drop_cnt_q;
    logic [15:0]           drop_cnt_d;
    logic [1:0]            oor_inc;
    logic [1:0]            drop_inc;

    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_oor;
    logic                  rd_oor;
    logic [MEM_AW-1:0]     wr_idx;
    logic [MEM_AW-1:0]     rd_idx;

    function automatic logic [15:0] sat_add(input logic [15:0] c,
                                            input logic [1:0]  inc);
        logic [16:0] s;
        s = {1'b0, c} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign wr_idx = app_wr_addr[MEM_AW-1:0];
    assign rd_idx = app_rd_addr[MEM_AW-1:0];
    assign wr_oor = |app_wr_addr[ADDR_WIDTH-1:MEM_AW];
    assign rd_oor = |app_rd_addr[ADDR_WIDTH-1:MEM_AW];

    // calib_done_q is high exactly while the FSM sits in READY
    assign wr_ok = app_wr_cmd && calib_done_q;
    assign rd_ok = app_rd_cmd && calib_done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= CALIB;
            calib_cnt_q  <= '0;
            calib_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                CALIB: begin
                    if (calib_cnt_q == CW'(CALIB_CYCLES - 1)) begin
                        state_q      <= READY;
                        calib_done_q <= 1'b1;
                    end else begin
                        calib_cnt_q <= calib_cnt_q + CW'(1);
                    end
                end
                READY: begin
                    calib_done_q <= 1'b1;
                end
                default: begin
                    state_q      <= CALIB;
                    calib_done_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            for (int i = 0; i < BW_WIDTH; i++) begin
                if (!app_wr_bw_n[i]) begin
                    mem[wr_idx][i*LANE_W +: LANE_W] <=
                        app_wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Stage 0 is the RAM read itself; NBA ordering gives read-before-write
    always_ff @(posedge clk) begin
        if (rd_ok) begin
            pipe_d_q[0] <= mem[rd_idx];
        end
        for (int i = 1; i < PD; i++) begin
            pipe_d_q[i] <= pipe_d_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v_q <= '0;
        end else begin
            pipe_v_q[0] <= rd_ok;
            for (int i = 1; i < PD; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= pipe_v_q[PD-1];
            if (pipe_v_q[PD-1]) begin
                rd_data_q <= pipe_d_q[PD-1];
            end
        end
    end

    always_comb begin
        drop_inc   = 2'd0;
        oor_inc    = 2'd0;
        if (!calib_done_q) begin
            drop_inc = {1'b0, app_wr_cmd} + {1'b0, app_rd_cmd};
        end
        oor_inc    = {1'b0, wr_ok && wr_oor} + {1'b0, rd_ok && rd_oor};
        drop_cnt_d = sat_add(drop_cnt_q, drop_inc);
        oor_cnt_d  = sat_add(oor_cnt_q, oor_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oor_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            oor_cnt_q  <= oor_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign app_rd_data         = rd_data_q;
    assign app_rd_valid        = rd_valid_q;
    assign init_calib_complete = calib_done_q;
    assign oor_cnt             = oor_cnt_q;
    assign drop_cnt            = drop_cnt_q;

endmodule

// File: tb/tb_qdriip_ui_mem_model.sv
// Bench for qdriip_ui_mem_model: random and directed traffic checked
// against a word-array memory model with a due-cycle read queue.
module tb_qdriip_ui_mem_model;

    localparam int AW  = 22;
    localparam int DW  = 72;
    localparam int BW  = 8;
    localparam int MAW = 10;
    localparam int LAT = 4;
    localparam int CAL = 64;
    localparam int LW  = DW / BW;
    localparam int DEP = 1 << MAW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          app_wr_cmd = 1'b0;
    logic [AW-1:0] app_wr_addr = '0;
    logic [DW-1:0] app_wr_data = '0;
    logic [BW-1:0] app_wr_bw_n = '1;
    logic          app_rd_cmd = 1'b0;
    logic [AW-1:0] app_rd_addr = '0;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_valid;
    logic          init_calib_complete;
    logic [15:0]   oor_cnt;
    logic [15:0]   drop_cnt;

    qdriip_ui_mem_model #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BW_WIDTH(BW),
        .MEM_AW(MAW), .RD_LATENCY(LAT), .CALIB_CYCLES(CAL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .app_wr_cmd(app_wr_cmd), .app_wr_addr(app_wr_addr),
        .app_wr_data(app_wr_data), .app_wr_bw_n(app_wr_bw_n),
        .app_rd_cmd(app_rd_cmd), .app_rd_addr(app_rd_addr),
        .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid),
        .init_calib_complete(init_calib_complete),
        .oor_cnt(oor_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [DW-1:0] d;
        logic [DW-1:0] m;
    } exp_t;

    exp_t          q[$];
    int            vq[$];
    logic [DW-1:0] mm [DEP];
    logic [DW-1:0] km [DEP];
    int            cyc;
    int            rel;
    int            m_oor;
    int            m_drop;
    int            n_cmp;
    int            n_bad;

    function automatic logic [DW-1:0] lane_mask(input logic [BW-1:0] bw_n);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < BW; i++)
            if (!bw_n[i]) m[i*LW +: LW] = '1;
        return m;
    endfunction

    function automatic logic [DW-1:0] rnd72();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic step(input logic wr, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [BW-1:0] bw,
                        input logic rd, input logic [AW-1:0] ra,
                        input logic rn);
        exp_t          e;
        logic [DW-1:0] m;
        int            wi;
        int            ri;
        app_wr_cmd  = wr;
        app_wr_addr = wa;
        app_wr_data = wd;
        app_wr_bw_n = bw;
        app_rd_cmd  = rd;
        app_rd_addr = ra;
        rst_n       = rn;
        @(posedge clk);
        cyc++;
        wi = int'(wa) % DEP;
        ri = int'(ra) % DEP;
        if (!rn) begin
            rel = 0;
            q.delete();
            m_oor  = 0;
            m_drop = 0;
        end else begin
            if (rel >= CAL) begin
                if (rd) begin
                    e.due = cyc + LAT - 1;
                    e.d   = mm[ri];
                    e.m   = km[ri];
                    q.push_back(e);
                    if (int'(ra) >= DEP) m_oor = sat16(m_oor + 1);
                end
                if (wr) begin
                    m = lane_mask(bw);
                    mm[wi] = (mm[wi] & ~m) | (wd & m);
                    km[wi] = km[wi] | m;
                    if (int'(wa) >= DEP) m_oor = sat16(m_oor + 1);
                end
            end else begin
                m_drop = sat16(m_drop + int'(wr) + int'(rd));
            end
            rel++;
        end
        #1;
        if (app_rd_valid) begin
            vq.push_back(cyc);
            n_cmp++;
            if (q.size() == 0 || q[0].due != cyc) begin
                n_bad++;
                $display("FAIL rd_valid_timing cyc=%0d got valid=1 want 0", cyc);
            end else begin
                e = q.pop_front();
                n_cmp++;
                if ((app_rd_data & e.m) !== (e.d & e.m)) begin
                    n_bad++;
                    $display("FAIL rd_data cyc=%0d got %h want %h",
                             cyc, app_rd_data & e.m, e.d & e.m);
                end
            end
        end else if (q.size() != 0 && q[0].due == cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_valid_missing cyc=%0d got 0 want 1", cyc);
            void'(q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '1, 0, '0, 1);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [BW-1:0] bw);
        step(1, a, d, bw, 0, '0, 1);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(0, '0, '0, '1, 1, a, 1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(0, '0, '0, '1, 0, '0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({app_rd_valid, init_calib_complete} !== 2'b00 ||
            app_rd_data !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got v=%b ic=%b d=%h want 0 0 0",
                     app_rd_valid, init_calib_complete, app_rd_data);
        end
        n_cmp++;
        if (oor_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_counters got %0d %0d want 0 0",
                     oor_cnt, drop_cnt);
        end
        for (int k = 1; k <= CAL + 4; k++) begin
            idle(1);
            n_cmp++;
            if (init_calib_complete !== (k >= CAL)) begin
                n_bad++;
                $display("FAIL calib_rise k=%0d got %b want %b",
                         k, init_calib_complete, (k >= CAL));
            end
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] d;
        d = 72'h12_3456_789A_BCDE_F012;
        wr(22'h5, d, 8'h00);
        rd(22'h5);
        idle(LAT + 2);
        n_cmp++;
        if (app_rd_data !== d) begin
            n_bad++;
            $display("FAIL basic_hold got %h want %h", app_rd_data, d);
        end
    endtask

    task automatic test_lanes();
        logic [DW-1:0] want;
        want = {{(DW - LW){1'b1}}, {LW{1'b0}}};
        wr(22'h7, '1, 8'h00);
        wr(22'h7, '0, 8'hFE);
        rd(22'h7);
        idle(LAT);
        n_cmp++;
        if (app_rd_data !== want) begin
            n_bad++;
            $display("FAIL lane_write got %h want %h", app_rd_data, want);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 10; a++) wr(AW'(a), rnd72(), 8'h00);
        vq.delete();
        for (int a = 0; a < 10; a++) rd(AW'(a));
        idle(LAT + 2);
        n_cmp++;
        if (vq.size() != 10) begin
            n_bad++;
            $display("FAIL b2b_count got %0d want 10", vq.size());
        end else begin
            n_cmp++;
            if (vq[9] - vq[0] != 9) begin
                n_bad++;
                $display("FAIL b2b_gaps got span %0d want 9", vq[9] - vq[0]);
            end
        end
    endtask

    task automatic test_alias();
        wr(22'h400, rnd72(), 8'h00);
        rd(22'h3FC00);
        wr(22'h3FC00, rnd72(), 8'h00);
        rd(22'h400);
        rd(22'h000);
        idle(LAT + 1);
        n_cmp++;
        if (oor_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL alias_oor got %0d want 4", oor_cnt);
        end
        n_cmp++;
        if (drop_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL alias_drop got %0d want 0", drop_cnt);
        end
    endtask

    task automatic test_calib_drop();
        do_reset();
        wr(22'h5, rnd72(), 8'h00);
        rd(22'h5);
        wr(22'h7, rnd72(), 8'h00);
        rd(22'h0);
        wr(22'h0, rnd72(), 8'h00);
        n_cmp++;
        if (drop_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL calib_drop got %0d want 5", drop_cnt);
        end
        idle(CAL);
        n_cmp++;
        if (init_calib_complete !== 1'b1 || oor_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL calib_ready got ic=%b oor=%0d want 1 0",
                     init_calib_complete, oor_cnt);
        end
        rd(22'h5);
        rd(22'h7);
        rd(22'h0);
        idle(LAT);
    endtask

    task automatic test_random();
        logic          w;
        logic          r;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [BW-1:0] bw;
        for (int i = 0; i < 400; i++) begin
            w  = ($urandom_range(0, 2) != 0);
            r  = ($urandom_range(0, 2) != 0);
            wa = AW'($urandom_range(0, 15));
            ra = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) wa[AW-1:MAW] = 12'($urandom());
            if ($urandom_range(0, 3) == 0) ra[AW-1:MAW] = 12'($urandom());
            bw = 8'($urandom());
            if ($urandom_range(0, 3) == 0) bw = 8'h00;
            step(w, wa, rnd72(), bw, r, ra, 1);
        end
        idle(LAT + 1);
        n_cmp++;
        if (int'(oor_cnt) != m_oor || int'(drop_cnt) != m_drop) begin
            n_bad++;
            $display("FAIL random_counters got %0d %0d want %0d %0d",
                     oor_cnt, drop_cnt, m_oor, m_drop);
        end
    endtask

    task automatic test_reset_inflight();
        rd(22'h1);
        rd(22'h2);
        rd(22'h3);
        step(0, '0, '0, '1, 0, '0, 0);
        n_cmp++;
        if (app_rd_data !== '0) begin
            n_bad++;
            $display("FAIL inflight_data got %h want 0", app_rd_data);
        end
        for (int i = 0; i < LAT + 3; i++) begin
            idle(1);
            n_cmp++;
            if (app_rd_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL inflight_valid i=%0d got %b want 0",
                         i, app_rd_valid);
            end
        end
        idle(CAL);
        rd(22'h5);
        idle(LAT);
    endtask

    initial begin
        cyc    = 0;
        rel    = 0;
        m_oor  = 0;
        m_drop = 0;
        n_cmp  = 0;
        n_bad  = 0;
        for (int i = 0; i < DEP; i++) begin
            mm[i] = '0;
            km[i] = '0;
        end
        test_reset();
        test_basic();
        test_lanes();
        test_back_to_back();
        test_alias();
        test_calib_drop();
        test_random();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
